// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a 1W/1R registered-read memory.
// Optional out-of-range address check when MEM_ARB_ADDR_CHECK_EN is defined.
module mem_port_arbiter #(
  parameter  int MEM_SIZE  = 6,
  parameter  int DATA_W    = 10,
  localparam int ADDR_SIZE = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [DATA_W-1:0]    wdata0,
  output logic                 gnt0,
  output logic                 rvalid0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [DATA_W-1:0]    wdata1,
  output logic                 gnt1,
  output logic                 rvalid1,
  output logic [DATA_W-1:0]    rdata,
  output logic                 err,
  output logic                 mem_write_flag,
  output logic [DATA_W-1:0]    mem_data_in,
  output logic [ADDR_SIZE-1:0] mem_addr_w,
  output logic                 mem_read_flag,
  output logic [ADDR_SIZE-1:0] mem_addr_r,
  input  logic [DATA_W-1:0]    mem_data_in_r
);

  logic                 ptr;
  logic                 el0, el1, win0, win1, win_any;
  logic                 win_we, bad;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [DATA_W-1:0]    win_wdata;
  logic                 rd0_q, rd1_q;

  // A requester is masked during its own grant cycle so a held req is not re-served.
  always_comb begin
    el0       = req0 & ~gnt0;
    el1       = req1 & ~gnt1;
    win0      = el0 & (~el1 | ~ptr);
    win1      = el1 & (~el0 | ptr);
    win_any   = win0 | win1;
    win_we    = win0 ? we0 : we1;
    win_addr  = win0 ? addr0 : addr1;
    win_wdata = win0 ? wdata0 : wdata1;
`ifdef MEM_ARB_ADDR_CHECK_EN
    bad       = win_any & (32'(win_addr) >= MEM_SIZE);
`else
    bad       = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr            <= 1'b0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      rd0_q          <= 1'b0;
      rd1_q          <= 1'b0;
      rvalid0        <= 1'b0;
      rvalid1        <= 1'b0;
      mem_write_flag <= 1'b0;
      mem_read_flag  <= 1'b0;
      mem_addr_w     <= '0;
      mem_data_in    <= '0;
      mem_addr_r     <= '0;
    end else begin
      gnt0           <= win0;
      gnt1           <= win1;
      if (win_any) ptr <= win0;
      mem_write_flag <= win_any & win_we & ~bad;
      mem_read_flag  <= win_any & ~win_we & ~bad;
      if (win_any && win_we) begin
        mem_addr_w  <= win_addr;
        mem_data_in <= win_wdata;
      end
      if (win_any && !win_we) mem_addr_r <= win_addr;
      rd0_q   <= win0 & ~we0;
      rd1_q   <= win1 & ~we1;
      rvalid0 <= rd0_q;
      rvalid1 <= rd1_q;
    end
  end

`ifdef MEM_ARB_ADDR_CHECK_EN
  logic bad_rd_q, rzero_q;

  // Rejected reads still return an rvalid, carrying zero instead of memory data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      bad_rd_q <= 1'b0;
      rzero_q  <= 1'b0;
    end else begin
      err      <= bad;
      bad_rd_q <= bad & ~win_we;
      rzero_q  <= bad_rd_q;
    end
  end

  assign rdata = rzero_q ? '0 : mem_data_in_r;
`else
  assign err   = 1'b0;
  assign rdata = mem_data_in_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural registered-read memory.
// Address-check steps run only when MEM_ARB_ADDR_CHECK_EN is defined.
module tb_mem_port_arbiter;
  localparam int MEM_SIZE = 6;
  localparam int DATA_W   = 10;
  localparam int AW       = $clog2(MEM_SIZE);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, we0, req1, we1;
  logic [AW-1:0]     addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, err;
  logic [DATA_W-1:0] rdata;
  logic              mem_write_flag, mem_read_flag;
  logic [DATA_W-1:0] mem_data_in;
  logic [AW-1:0]     mem_addr_w, mem_addr_r;
  logic [DATA_W-1:0] mdout = '0;
  logic [DATA_W-1:0] mem [MEM_SIZE];
  logic [6:0]        flags;
  int                total = 0;
  int                bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_SIZE(MEM_SIZE), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .err(err),
    .mem_write_flag(mem_write_flag), .mem_data_in(mem_data_in), .mem_addr_w(mem_addr_w),
    .mem_read_flag(mem_read_flag), .mem_addr_r(mem_addr_r), .mem_data_in_r(mdout)
  );

  always @(posedge clk) begin
    if (mem_write_flag && 32'(mem_addr_w) < MEM_SIZE) mem[mem_addr_w] <= mem_data_in;
    if (mem_read_flag && 32'(mem_addr_r) < MEM_SIZE) mdout <= mem[mem_addr_r];
  end

  // Bit order: gnt0 gnt1 rvalid0 rvalid1 err write_flag read_flag
  assign flags = {gnt0, gnt1, rvalid0, rvalid1, err, mem_write_flag, mem_read_flag};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = '0;
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    tick(); tick();
    chk("reset_flags", 32'(flags), 32'b0000000);
    chk("reset_rdata", 32'(rdata), 32'h000);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_flags", 32'(flags), 32'b0000000);

    // single write, then read back
    req0 = 1; we0 = 1; addr0 = 3'd0; wdata0 = 10'h123;
    tick();
    chk("wr_flags", 32'(flags), 32'b1000010);
    chk("wr_addr", 32'(mem_addr_w), 32'd0);
    chk("wr_data", 32'(mem_data_in), 32'h123);
    req0 = 0;
    tick();
    chk("wr_after", 32'(flags), 32'b0000000);
    req0 = 1; we0 = 0; addr0 = 3'd0;
    tick();
    chk("rd_flags", 32'(flags), 32'b1000001);
    chk("rd_addr", 32'(mem_addr_r), 32'd0);
    req0 = 0;
    tick();
    chk("rd_rvalid", 32'(flags), 32'b0010000);
    chk("rd_rdata", 32'(rdata), 32'h123);

    // pointer is at 1 now; reset must return it to 0
    rst_n = 1'b0;
    tick();
    chk("rst_pulse", 32'(flags), 32'b0000000);
    rst_n = 1'b1;
    tick();

    // contention: write then read of the same address
    req0 = 1; we0 = 1; addr0 = 3'd1; wdata0 = 10'h0BC;
    req1 = 1; we1 = 0; addr1 = 3'd1;
    tick();
    chk("cont_g0", 32'(flags), 32'b1000010);
    chk("cont_waddr", 32'(mem_addr_w), 32'd1);
    chk("cont_wdata", 32'(mem_data_in), 32'h0BC);
    req0 = 0;
    tick();
    chk("cont_g1", 32'(flags), 32'b0100001);
    chk("cont_raddr", 32'(mem_addr_r), 32'd1);
    chk("cont_waddr_hold", 32'(mem_addr_w), 32'd1);
    req1 = 0;
    tick();
    chk("cont_rv1", 32'(flags), 32'b0001000);
    chk("cont_rdata", 32'(rdata), 32'h0BC);

    // fairness: both hold reads continuously
    req0 = 1; we0 = 0; addr0 = 3'd0;
    req1 = 1; we1 = 0; addr1 = 3'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 0) begin
        chk("fair_even", 32'(flags), (i == 0) ? 32'b1000001 : 32'b1001001);
        if (i > 0) chk("fair_rdata1", 32'(rdata), 32'h0BC);
      end else begin
        chk("fair_odd", 32'(flags), 32'b0110001);
        chk("fair_rdata0", 32'(rdata), 32'h123);
      end
    end
    req0 = 0; req1 = 0;
    tick();
    chk("fair_tail", 32'(flags), 32'b0001000);
    chk("fair_tail_rdata", 32'(rdata), 32'h0BC);
    tick();
    chk("fair_idle", 32'(flags), 32'b0000000);

    // reset between a read grant and its rvalid
    req1 = 1; we1 = 0; addr1 = 3'd1;
    tick();
    chk("mid_g1", 32'(flags), 32'b0100001);
    req1 = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_async", 32'(flags), 32'b0000000);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mid_no_rv", 32'(flags), 32'b0000000);

    // move pointer to 1, reset, then contention must go to requester 0
    req0 = 1; we0 = 0; addr0 = 3'd0;
    tick();
    chk("ptr_g0", 32'(flags), 32'b1000001);
    req0 = 0;
    tick();
    chk("ptr_rv0", 32'(flags), 32'b0010000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req0 = 1; req1 = 1;
    tick();
    chk("ptr_reset_win0", 32'(flags), 32'b1000001);
    req0 = 0; req1 = 0;
    tick();
    chk("ptr_reset_rv0", 32'(flags), 32'b0010000);
    tick();

`ifdef MEM_ARB_ADDR_CHECK_EN
    req0 = 1; we0 = 1; addr0 = 3'd7; wdata0 = 10'h3FF;
    tick();
    chk("chk_wr7", 32'(flags), 32'b1000100);
    req0 = 0;
    tick();
    chk("chk_wr7_after", 32'(flags), 32'b0000000);
    req1 = 1; we1 = 0; addr1 = 3'd1;
    tick();
    chk("chk_rd1_g", 32'(flags), 32'b0100001);
    req1 = 0;
    tick();
    chk("chk_rd1_rv", 32'(flags), 32'b0001000);
    chk("chk_rd1_data", 32'(rdata), 32'h0BC);
    req0 = 1; we0 = 0; addr0 = 3'd6;
    tick();
    chk("chk_rd6_g", 32'(flags), 32'b1000100);
    req0 = 0;
    tick();
    chk("chk_rd6_rv", 32'(flags), 32'b0010000);
    chk("chk_rd6_data", 32'(rdata), 32'h000);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
